register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file that feeds the pipeline's 32-bit `Register` stage latches: two synchronous read ports and one write-back port.
- Includes a per-register busy scoreboard, so the decode stage can detect RAW hazards against in-flight producers.
- Read data and the hazard flag are registered, so they land in the same cycle as a downstream pipeline latch load.

Parameters:
- DATA_WIDTH, 32, width of each register and data port
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH (32)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- rs_addr  input  ADDR_WIDTH  read port A address
- rt_addr  input  ADDR_WIDTH  read port B address
- rs_data  output  DATA_WIDTH  registered read data A
- rt_data  output  DATA_WIDTH  registered read data B
- wb_en  input  1  write-back enable
- wb_addr  input  ADDR_WIDTH  write-back address
- wb_data  input  DATA_WIDTH  write-back data
- issue_valid  input  1  an instruction with a destination is issued this cycle
- issue_rd  input  ADDR_WIDTH  destination of the issued instruction
- hazard  output  1  registered: a source read last cycle was busy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset: on a posedge with reset=1, all NUM_REGS entries, all busy bits, rs_data, rt_data and hazard go to 0. Every other input in that cycle is ignored. A reset mid-operation discards pending writes and issues.
- Register 0: always reads as 0, writes to it are dropped, and its busy bit is never set.
- Write: on a posedge with wb_en=1 and wb_addr!=0, mem[wb_addr] <= wb_data.
- Read latency: 1 cycle. At posedge, rs_data <= mem[rs_addr] and rt_data <= mem[rt_addr]; both ports read every cycle, with no read enable.
- Same-address write and read in one cycle: governed by the optional feature below.
- Scoreboard set: issue_valid=1 with issue_rd!=0 sets busy[issue_rd] at the posedge.
- Scoreboard clear: wb_en=1 with wb_addr!=0 clears busy[wb_addr] at the posedge.
- Issue and write-back to the same register in one cycle: set wins, and busy stays 1 because a new producer is outstanding.
- Hazard: at posedge, hazard <= busy[rs_addr] | busy[rt_addr], using busy as it stood before this edge's update.
  - Exception: a source being written back this cycle counts as not busy.
  - Address 0 never flags.
- No state machine beyond the storage and scoreboard bits.
- No arithmetic, so there is no wrap-around. Address range is exactly NUM_REGS, so no address is out of range.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address equals wb_addr while wb_en=1 (and address !=0) returns wb_data in the same edge, i.e. write-through.
- Undefined: that read returns the old stored value. The new value is visible one cycle later.
- Hazard clearing on same-cycle write-back applies in both builds.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - NUM_REGS
  - ZERO_REG = 0
  - typedefs reg_addr_t and reg_data_t
- One natural sub-module: regfile_scoreboard, which holds the busy[NUM_REGS] vector plus the set/clear/hazard logic.
- Storage and read ports stay in the top module.

Test Plan:
- Reset: preload via writes, assert reset for 1 cycle, then read addrs 1 and 31 -> rs_data=0, rt_data=0, hazard=0.
- Write/read: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; next cycle rs_addr=5 -> rs_data=0xDEADBEEF one edge later.
- R0 and bypass: write 0x12345678 to addr 0 -> reading addr 0 returns 0.
  - Simultaneous write of 0xA5A5A5A5 to addr 7 and read of addr 7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value without it.
- Scoreboard: issue_rd=9, next cycle rs_addr=9 -> hazard=1.
  - Then wb_en=1 to addr 9 with rs_addr=9 on the same edge -> hazard=0.
- Set-wins: issue_rd=3 and wb_addr=3 on the same edge -> busy[3] stays 1; next-cycle read of addr 3 -> hazard=1.
- Reset mid-issue: issue_rd=4 with reset=1 -> busy[4]=0; next-cycle read of addr 4 -> hazard=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the register file slice: widths, register count and
// address/data types.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/register_file_if.sv
// Read, write-back and issue/hazard signals between decode/write-back logic
// (master) and the register file (slave).
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH,
    parameter int unsigned AW = ADDR_WIDTH
);

    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          hazard;

    modport master (
        output rs_addr, rt_addr, wb_en, wb_addr, wb_data, issue_valid, issue_rd,
        input  rs_data, rt_data, hazard
    );

    modport slave (
        input  rs_addr, rt_addr, wb_en, wb_addr, wb_data, issue_valid, issue_rd,
        output rs_data, rt_data, hazard
    );

endinterface

// File: rtl/register_file_scoreboard.sv
// Busy scoreboard: issue sets, write-back clears, and a registered RAW hazard
// flag for the two source addresses.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          hazard
);

    localparam int unsigned NR = 2 ** AW;

    logic [NR-1:0] busy;
    logic          wb_hit;
    logic          rs_busy;
    logic          rt_busy;

    // A source whose producer writes back on this edge is already resolved.
    always_comb begin
        wb_hit  = wb_en && (wb_addr != '0);
        rs_busy = busy[rs_addr] && (rs_addr != '0) && !(wb_hit && (wb_addr == rs_addr));
        rt_busy = busy[rt_addr] && (rt_addr != '0) && !(wb_hit && (wb_addr == rt_addr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            hazard <= 1'b0;
        end else begin
            if (wb_hit)
                busy[wb_addr] <= 1'b0;
            // Placed after the clear so a same-register issue wins.
            if (issue_valid && (issue_rd != '0))
                busy[issue_rd] <= 1'b1;
            hazard <= rs_busy | rt_busy;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: two registered read ports, one write-back port,
// busy scoreboard. Optional macro REGFILE_BYPASS_EN enables write-through reads.
module register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH,
    parameter int unsigned AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    register_file_if.slave bus
);

    localparam int unsigned NR = 2 ** AW;

    logic [DW-1:0] mem [NR];
    logic          wb_hit;
    logic [DW-1:0] rs_next;
    logic [DW-1:0] rt_next;

    always_comb begin
        wb_hit  = bus.wb_en && (bus.wb_addr != '0);
        rs_next = mem[bus.rs_addr];
        rt_next = mem[bus.rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_hit && (bus.wb_addr == bus.rs_addr))
            rs_next = bus.wb_data;
        if (wb_hit && (bus.wb_addr == bus.rt_addr))
            rt_next = bus.wb_data;
`endif
    end

    // Entry 0 is cleared on reset and never written, so it always reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NR; i++)
                mem[i] <= '0;
            bus.rs_data <= '0;
            bus.rt_data <= '0;
        end else begin
            if (wb_hit)
                mem[bus.wb_addr] <= bus.wb_data;
            bus.rs_data <= rs_next;
            bus.rt_data <= rt_next;
        end
    end

    regfile_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .rs_addr     (bus.rs_addr),
        .rt_addr     (bus.rt_addr),
        .wb_en       (bus.wb_en),
        .wb_addr     (bus.wb_addr),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .hazard      (bus.hazard)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (honours REGFILE_BYPASS_EN).
module tb_register_file;
    import regfile_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        idle();
    endtask

    logic [31:0] exp_bypass;

    initial begin
        total = 0;
        bad   = 0;
        idle();
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_rs_data", bus.rs_data, 32'h0);
        check("reset_rt_data", bus.rt_data, 32'h0);
        check("reset_hazard", {31'b0, bus.hazard}, 32'h0);

        // Basic write then read one cycle later
        write(5'd5, 32'hDEADBEEF);
        bus.rs_addr = 5'd5;
        tick();
        check("wr_rd_5", bus.rs_data, 32'hDEADBEEF);

        // Register 0 ignores writes
        write(5'd0, 32'h12345678);
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;
        tick();
        check("r0_rs", bus.rs_data, 32'h0);
        check("r0_rt", bus.rt_data, 32'h0);

        // Same-edge write and read of address 7
        write(5'd7, 32'h01010101);
        bus.rs_addr = 5'd7;
        bus.rt_addr = 5'd5;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'hA5A5A5A5;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'hA5A5A5A5;
`else
        exp_bypass = 32'h01010101;
`endif
        check("same_edge_rs_7", bus.rs_data, exp_bypass);
        check("same_edge_rt_5", bus.rt_data, 32'hDEADBEEF);
        tick();
        check("after_write_7", bus.rs_data, 32'hA5A5A5A5);

        // Scoreboard set via issue, seen on rs
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        bus.rs_addr     = 5'd0;
        bus.rt_addr     = 5'd0;
        tick();
        idle();
        bus.rs_addr = 5'd9;
        tick();
        check("hazard_rs_9", {31'b0, bus.hazard}, 32'h1);
        // Write-back on the same edge as the read masks the hazard
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'h00000099;
        tick();
        idle();
        check("hazard_wb_same_edge_9", {31'b0, bus.hazard}, 32'h0);
        tick();
        check("hazard_cleared_9", {31'b0, bus.hazard}, 32'h0);
        check("data_9", bus.rs_data, 32'h00000099);

        // Hazard via rt port
        bus.rs_addr     = 5'd0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd10;
        tick();
        idle();
        bus.rt_addr = 5'd10;
        tick();
        check("hazard_rt_10", {31'b0, bus.hazard}, 32'h1);
        write(5'd10, 32'h0000000A);
        check("hazard_rt_10_wb", {31'b0, bus.hazard}, 32'h0);

        // Issue to register 0 never sets busy
        bus.rt_addr     = 5'd0;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        tick();
        idle();
        tick();
        check("hazard_r0", {31'b0, bus.hazard}, 32'h0);

        // Issue and write-back to the same register: set wins
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        bus.wb_en       = 1'b1;
        bus.wb_addr     = 5'd3;
        bus.wb_data     = 32'h00000033;
        tick();
        idle();
        bus.rs_addr = 5'd3;
        tick();
        check("set_wins_hazard_3", {31'b0, bus.hazard}, 32'h1);
        check("set_wins_data_3", bus.rs_data, 32'h00000033);

        // Preload 1 and 31, then reset with an issue pending on 4
        write(5'd1, 32'h11111111);
        write(5'd31, 32'h31313131);
        bus.rs_addr = 5'd1;
        bus.rt_addr = 5'd31;
        tick();
        check("preload_1", bus.rs_data, 32'h11111111);
        check("preload_31", bus.rt_data, 32'h31313131);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        bus.wb_en       = 1'b1;
        bus.wb_addr     = 5'd1;
        bus.wb_data     = 32'hFFFFFFFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("rst_rs_data", bus.rs_data, 32'h0);
        check("rst_hazard", {31'b0, bus.hazard}, 32'h0);
        tick();
        check("post_rst_1", bus.rs_data, 32'h0);
        check("post_rst_31", bus.rt_data, 32'h0);
        bus.rs_addr = 5'd4;
        bus.rt_addr = 5'd3;
        tick();
        check("post_rst_hazard_4_3", {31'b0, bus.hazard}, 32'h0);
        check("post_rst_data_3", bus.rt_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
